// File: rtl/viterbi_k3_pkg.sv
// Shared constants and helpers for the rate-1/2, K=3 (7,5) Viterbi decoder.
// Trellis states are {u[n-1], u[n-2]}; symbols are {g0 bit, g1 bit}.
package viterbi_k3_pkg;

  localparam int         K      = 3;
  localparam int         NSTATE = 4;
  localparam logic [2:0] G0     = 3'b111;
  localparam logic [2:0] G1     = 3'b101;

  // Encoder output {v0,v1} when input u is applied in trellis state 'state'.
  function automatic logic [1:0] enc_out(input logic [1:0] state, input logic u);
    logic [2:0] shiftReg;
    shiftReg = {u, state};
    return {^(shiftReg & G0), ^(shiftReg & G1)};
  endfunction

  function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] diff;
    diff = a ^ b;
    return {1'b0, diff[1]} + {1'b0, diff[0]};
  endfunction

endpackage

// File: rtl/viterbi_acs_k3.sv
// Combinational add-compare-select for all four trellis states, followed by
// normalization so the smallest outgoing metric is always zero.
module viterbi_acs_k3
  import viterbi_k3_pkg::*;
#(
  parameter int PM_W = 6
) (
  input  logic [NSTATE-1:0][PM_W-1:0] i_pm,
  input  logic [1:0]                  i_sym,
  output logic [NSTATE-1:0][PM_W-1:0] o_pm,
  output logic [NSTATE-1:0]           o_dec,
  output logic [PM_W:0]               o_min
);

  logic [NSTATE-1:0][PM_W:0] w_sel;
  logic [PM_W:0]             w_min;

  // Next state {u,a} is reached from {a,0} or {a,1}; ties keep the s0=0 predecessor.
  for (genvar ns = 0; ns < NSTATE; ns++) begin : g_acs
    localparam logic [1:0] NS = 2'(ns);
    localparam logic [1:0] P0 = {NS[0], 1'b0};
    localparam logic [1:0] P1 = {NS[0], 1'b1};
    logic [PM_W:0] w_c0;
    logic [PM_W:0] w_c1;
    assign w_c0      = {1'b0, i_pm[P0]} + (PM_W+1)'(hamming2(i_sym, enc_out(P0, NS[1])));
    assign w_c1      = {1'b0, i_pm[P1]} + (PM_W+1)'(hamming2(i_sym, enc_out(P1, NS[1])));
    assign o_dec[ns] = (w_c1 < w_c0);
    assign w_sel[ns] = (w_c1 < w_c0) ? w_c1 : w_c0;
  end

  always_comb begin
    w_min = w_sel[0];
    for (int i = 1; i < NSTATE; i++) begin
      if (w_sel[i] < w_min) w_min = w_sel[i];
    end
  end

  always_comb begin
    o_pm = '0;
    for (int i = 0; i < NSTATE; i++) begin
      o_pm[i] = PM_W'(w_sel[i] - w_min);
    end
  end

  assign o_min = w_min;

endmodule

// File: rtl/viterbi_dec_k3.sv
// Hard-decision register-exchange Viterbi decoder for the K=3 (7,5) code.
// One symbol per rx_valid cycle; decoded bits emerge TB_DEPTH accepted symbols later.
module viterbi_dec_k3
  import viterbi_k3_pkg::*;
#(
  parameter int TB_DEPTH = 16,
  parameter int PM_W     = 6
) (
  input  logic       clk_sig,
  input  logic       reset_sig,
  input  logic       rx_valid,
  input  logic [1:0] rx_sym,
  output logic       dec_valid,
  output logic       dec_bit,
  output logic       err_sig
);

  localparam int             FILL_W  = $clog2(TB_DEPTH + 1);
  localparam int             PM_MAX  = (1 << PM_W) - 1;
  localparam logic [PM_W-1:0] PM_INIT = PM_W'((PM_MAX > 4) ? 4 : PM_MAX);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(TB_DEPTH);

  logic [NSTATE-1:0][PM_W-1:0]     r_pm;
  logic [NSTATE-1:0][TB_DEPTH-1:0] r_surv;
  logic [FILL_W-1:0]               r_fillCnt;
  logic                            r_decValid;
  logic                            r_decBit;
  logic                            r_err;

  logic [NSTATE-1:0][PM_W-1:0]     w_newPm;
  logic [NSTATE-1:0]               w_dec;
  logic [PM_W:0]                   w_min;
  logic [NSTATE-1:0][TB_DEPTH-1:0] w_survNext;
  logic [NSTATE-1:0]               w_lost;
  logic [1:0]                      w_best;

  viterbi_acs_k3 #(.PM_W(PM_W)) u_acs (
    .i_pm  (r_pm),
    .i_sym (rx_sym),
    .o_pm  (w_newPm),
    .o_dec (w_dec),
    .o_min (w_min)
  );

  // The bit pushed out of a survivor is the decision made TB_DEPTH symbols ago.
  for (genvar ns = 0; ns < NSTATE; ns++) begin : g_surv
    localparam logic [1:0] NS = 2'(ns);
    logic [1:0] w_pred;
    assign w_pred         = {NS[0], w_dec[ns]};
    assign w_survNext[ns] = {r_surv[w_pred][TB_DEPTH-2:0], NS[1]};
    assign w_lost[ns]     = r_surv[w_pred][TB_DEPTH-1];
  end

  always_comb begin
    w_best = 2'd0;
    for (int i = NSTATE - 1; i >= 0; i--) begin
      if (w_newPm[i] == '0) w_best = 2'(i);
    end
  end

  always_ff @(posedge clk_sig or posedge reset_sig) begin
    if (reset_sig) begin
      for (int i = 0; i < NSTATE; i++) begin
        r_pm[i] <= (i == 0) ? '0 : PM_INIT;
      end
      r_surv     <= '0;
      r_fillCnt  <= '0;
      r_decValid <= 1'b0;
      r_decBit   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_decValid <= 1'b0;
      r_err      <= 1'b0;
      if (rx_valid) begin
        r_pm       <= w_newPm;
        r_surv     <= w_survNext;
        r_err      <= (w_min != '0);
        r_decBit   <= w_lost[w_best];
        r_decValid <= (r_fillCnt == FILL_FULL);
        if (r_fillCnt != FILL_FULL) r_fillCnt <= r_fillCnt + 1'b1;
      end
    end
  end

  assign dec_valid = r_decValid;
  assign dec_bit   = r_decBit;
  assign err_sig   = r_err;

endmodule

// File: doc/viterbi_dec_k3.md
Name: viterbi_dec_k3

Overview:
- Hard-decision Viterbi decoder for the rate-1/2, K=3 convolutional code with generators 7,5 (octal). This is the receive-side counterpart of the channel encoder.
- Consumes one 2-bit code symbol per accepted input, taken from the serial-to-parallel stage output.
- Produces one decoded information bit per accepted symbol after a fixed traceback delay.
- Uses register-exchange survivor storage, so there is no traceback FSM and no survivor RAM.

Parameters:
- TB_DEPTH, 16, survivor length in symbols; equals the decode latency in accepted symbols; legal range 8..32.
- PM_W, 6, path-metric width in bits; must satisfy 2^PM_W > 2*(K-1)+2.

Ports:
- clk_sig  input  1  decoder clock; one symbol is processed per cycle when rx_valid=1.
- reset_sig  input  1  asynchronous, active-high reset.
- rx_valid  input  1  rx_sym is valid this cycle.
- rx_sym  input  2  received code symbol; [1] = g0 (111) branch, [0] = g1 (101) branch.
- dec_valid  output  1  dec_bit is valid; a single-cycle pulse per decoded bit.
- dec_bit  output  1  decoded information bit.
- err_sig  output  1  one-cycle pulse: the best path metric grew on this symbol, i.e. a channel error was detected.

Behaviour:
- Trellis state s = {u[n-1], u[n-2]}, encoded as s1:s0.
- Encoder reference for input u: v0 = u^s1^s0, v1 = u^s0; next state = {u, s1}.
- Predecessors of next state {u,a} are {a,0} and {a,1}.
- Branch metric = Hamming distance between rx_sym and {v0,v1}, range 0..2, 2 bits wide.
- ACS runs once per cycle with rx_valid=1:
  - cand = PM[pred] + BM, computed at PM_W+1 bits.
  - Select the smaller candidate. On a tie, select the predecessor with s0=0.
  - New survivor = {selected pred survivor[TB_DEPTH-2:0], u}.
- Normalization, in the same cycle: subtract min(new metrics) from all four metrics before registering.
  - The stored minimum is therefore always 0.
  - Metrics never exceed 2*(K-1)+2, so there is no overflow and no wrap-around.
- err_sig = 1 in the cycle after acceptance when min(new metrics, pre-normalization) > 0. Otherwise err_sig = 0.
- Output path:
  - On the cycle after acceptance, dec_bit = survivor[TB_DEPTH-1] of the state with the minimum new metric. Ties resolve to the lowest state index.
  - dec_valid = 1 only if fill_cnt has reached TB_DEPTH.
- fill_cnt:
  - Counts accepted symbols and saturates at TB_DEPTH.
  - Its width is the clog2 of TB_DEPTH+1.
  - The first TB_DEPTH accepted symbols produce no dec_valid.
  - Symbol TB_DEPTH+1 produces the first decoded bit, which is the bit encoded by symbol 1.
- rx_valid=0: metrics, survivors, fill_cnt and dec_bit hold; dec_valid=0; err_sig=0. Gaps of any length are lossless.
- Reset values:
  - PM[0]=0 and PM[1..3]=2^(PM_W)-1 capped to 4, forcing the start state to 00.
  - Survivors = 0, fill_cnt = 0, dec_valid = 0, dec_bit = 0, err_sig = 0.
- Reset mid-stream aborts immediately and asynchronously. The next accepted symbol is treated as symbol 1 of a new stream.
- There is no flush input. The final TB_DEPTH bits of a stream are emitted only if further symbols follow, e.g. tail zeros.

Decomposition:
- Package viterbi_k3_pkg holds:
  - constants K=3, NSTATE=4, G0=3'b111, G1=3'b101;
  - function enc_out(state,u) returning {v0,v1};
  - function hamming2.
- One sub-module, viterbi_acs_k3: a combinational ACS plus normalization unit for all 4 states.
  - Inputs: PM vector, rx_sym.
  - Outputs: new PM vector, 4 decision bits, min metric.
- The top module owns:
  - the PM and survivor registers;
  - fill_cnt;
  - the best-state select and the output registers.

Test Plan:
- Reset then 40 symbols of 00 with rx_valid=1 -> dec_valid first at the cycle after symbol 17; all dec_bit = 0; err_sig never asserted.
- Info bits 1,0,1,1 then 16 zeros, encoded as 11,10,00,01,01,11,00,... -> dec_bit sequence 1,0,1,1,0... aligned with dec_valid; err_sig = 0 throughout.
- Same stream with bit [1] of symbol 3 flipped (00→10) -> identical decoded output; err_sig pulses on that symbol.
- Random 2000-bit info stream, encoded, with one flipped bit per 15 channel bits -> zero decoded bit errors after latency alignment; PM values never exceed 4.
- Stream from the 1,0,1,1 scenario with random 1–5 cycle rx_valid gaps -> decoded sequence identical to the gap-free run; dec_valid count equals accepted symbols minus 16.
- Assert reset_sig mid-stream after 10 symbols -> outputs 0 immediately. Re-send the 1,0,1,1 stream -> first dec_valid again after 17 accepted symbols, with correct bits.
